// File: rtl/truth_table_reader.sv
// truth_table_reader
//   Reads back the truth table of a small combinational gate. It drives every
//   input vector in ascending order, holds each one for SETTLE cycles and then
//   samples the gate output into table_out. It compares the finished table with
//   EXP_TABLE and offers the result over a valid/ready handshake.
//
//   Ports:
//     clk          rising-edge clock
//     rst_n        synchronous active-low reset
//     start        one-cycle read request; honoured only in IDLE
//     busy         high from the cycle after an accepted start until the handshake
//     dut_in       vector driven onto the gate (bit k -> gate input k)
//     dut_out      gate output under characterisation
//     result_valid table_out/match are valid
//     result_ready consumer accepts the result
//     table_out    bit i = dut_out sampled while dut_in == i
//     match        table_out == EXP_TABLE
module truth_table_reader #(
  parameter int                 N_IN      = 4,
  parameter int                 SETTLE    = 2,
  parameter logic [2**N_IN-1:0] EXP_TABLE = 16'h409B
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 match
);

  localparam int        TW       = 2**N_IN;
  // The settle counter is 4 bits wide because SETTLE is limited to 1..15.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESULT} state_t;

  state_t          state, state_nx;
  logic [N_IN-1:0] idx;
  logic [3:0]      cnt;
  logic            last_vec;
  logic [TW-1:0]   table_nx;

  // The last vector is detected explicitly, so idx never wraps into a second pass.
  always_comb begin
    last_vec      = (idx == '1);
    table_nx      = table_out;
    table_nx[idx] = dut_out;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)             state_nx = DRIVE;
      DRIVE:   if (cnt == CNT_LAST)   state_nx = SAMPLE;
      SAMPLE:  state_nx = last_vec ? RESULT : DRIVE;
      RESULT:  if (result_ready)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: vector index, settle counter, captured table and compare result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      cnt       <= '0;
      table_out <= '0;
      match     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx       <= '0;
            cnt       <= '0;
            table_out <= '0;
          end
        end
        DRIVE: cnt <= cnt + 4'd1;
        SAMPLE: begin
          table_out <= table_nx;
          if (last_vec) begin
            // Compare against the table including the bit sampled on this edge,
            // so match rises together with result_valid.
            match <= (table_nx == EXP_TABLE);
          end else begin
            idx <= idx + N_IN'(1);
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy         = (state != IDLE);
    result_valid = (state == RESULT);
    dut_in       = ((state == DRIVE) || (state == SAMPLE)) ? idx : '0;
  end

endmodule

// File: doc/truth_table_reader.md
# truth_table_reader

Sequential characterisation block that reads back the truth table of a 4-input, 1-output combinational gate netlist. It drives all 2^N_IN input vectors onto the gate in ascending order, waits a programmable settle time per vector, and samples the gate output into a packed truth-table word. It compares that word against an expected hex constant and returns the result over a valid/ready handshake. It sits next to each synthesised gate in the design-evaluation harness, the read side of the gate's truth-table encoding.

## Interface
Parameters:
- N_IN, 4, number of gate inputs; table width is 2**N_IN
- SETTLE, 2, cycles dut_in is held before dut_out is sampled (legal range 1..15)
- EXP_TABLE, 16'h409B, expected truth table, width 2**N_IN

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle request to begin a read; honoured only in IDLE
- busy  output  1  high from the cycle after an accepted start until result handshake completes
- dut_in  output  N_IN  vector driven to the gate; bit k drives gate input k
- dut_out  input  1  gate output being characterised
- result_valid  output  1  table_out/match valid
- result_ready  input  1  consumer accepts result
- table_out  output  2**N_IN  bit i = dut_out sampled while dut_in == i
- match  output  1  table_out == EXP_TABLE

## Operation
- States: IDLE, DRIVE, SAMPLE, RESULT.
- IDLE: busy=0, result_valid=0, dut_in=0.
  - start=1 → DRIVE with idx=0, settle counter=0, table_out cleared.
- DRIVE: dut_in=idx. The settle counter increments each cycle.
  - When counter == SETTLE-1 → SAMPLE.
- SAMPLE: table_out[idx] <= dut_out. dut_in stays at idx.
  - idx == 2**N_IN-1 → RESULT, match computed from the completed table.
  - Otherwise idx+1, counter=0 → DRIVE.
- RESULT: result_valid=1; table_out and match held stable.
  - result_valid=1 and result_ready=1 in the same cycle → IDLE.
  - result_valid is never dropped before acceptance.
- idx is N_IN bits wide. The last-vector check is explicit, so idx never wraps into a second pass.
- start outside IDLE is ignored, including start in the same cycle as the RESULT→IDLE handshake.
- dut_out is sampled only in SAMPLE and is don't-care elsewhere.
- table_out bits not yet sampled read 0 during a run.

## Timing
- Reset (rst_n=0 at a clock edge): state=IDLE, busy=0, result_valid=0, dut_in=0, table_out=0, match=0, idx=0, counter=0.
  - Reset asserted mid-run aborts the run; no partial result is reported.
- start sampled at edge 0 → busy=1 and dut_in=0 visible after edge 0.
- Per vector: SETTLE cycles in DRIVE + 1 cycle in SAMPLE.
- Latency from accepted start to result_valid: 2**N_IN*(SETTLE+1) cycles. Defaults: 16*3 = 48 cycles.
- result_valid and match rise on the same edge. table_out is final on that edge.
- After the handshake edge, busy=0 and result_valid=0. A new start is accepted on the following cycle at the earliest.
- table_out and match keep their last values in IDLE until the next accepted start clears table_out.

## Test plan
- Parity gate: bench ties dut_out = ^dut_in, defaults except EXP_TABLE=16'h6996; pulse start.
  - Required: result_valid at cycle 48, table_out=16'h6996, match=1, dut_in sequence 0..15 each held 3 cycles.
- Mismatch with defaults: dut_out = dut_in[3].
  - Required: table_out=16'hFF00, match=0.
- Back-pressure: hold result_ready=0 for 20 cycles after result_valid.
  - Required: result_valid, table_out and match stay stable throughout.
  - Raise result_ready for one cycle → IDLE next cycle, busy=0.
- Reset mid-run: pull rst_n low at idx=7 for one edge.
  - Required: all outputs 0 next cycle.
  - A new start then yields a full, correct 48-cycle run.
- Ignored start: pulse start during DRIVE, and again during the handshake cycle.
  - Required: no restart, latency unchanged, IDLE after the handshake.
- SETTLE=1 with dut_out = (dut_in==0).
  - Required: latency 32 cycles, table_out=16'h0001.
